ape_dec_seq: RTL and testbench

APE_DEC_SEQ -- requirements
Module: ape_dec_seq

---
 rtl/ape_pkg.sv | 42 ++++
 rtl/ape_pe.sv | 19 +
 rtl/ape_dec_seq.sv | 176 +++++++++++++++++
 tb/tb_ape_dec_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ape_pkg.sv
// Shared types and constants for the APE-style decryption sequencer.
// Latency: none (declarations and a pure combinational round helper only).
// Backpressure: n/a.
package ape_pkg;

    localparam int RATE_W = 34;
    localparam int CAP_W  = 16;
    localparam int KEY_W  = 64;
    localparam int PE_W   = RATE_W + CAP_W;

    // Round constants, one per permutation round
    localparam logic [PE_W-1:0] RC0 = 50'h1_3579_BDF0_2468;
    localparam logic [PE_W-1:0] RC1 = 50'h2_F0E1_D2C3_B4A5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } ape_state_e;

    typedef struct packed {
        logic [RATE_W-1:0] rate;
        logic [CAP_W-1:0]  cap;
    } ape_blk_t;

    // One permutation round: chi-like nonlinear mix against two rotations,
    // constant injection, then a rotate-left by 17 for diffusion.
    function automatic logic [PE_W-1:0] ape_round(input logic [PE_W-1:0] x,
                                                  input logic [PE_W-1:0] rc);
        logic [PE_W-1:0] a;
        logic [PE_W-1:0] b;
        logic [PE_W-1:0] y;
        a = {x[PE_W-6:0],  x[PE_W-1:PE_W-5]};
        b = {x[PE_W-12:0], x[PE_W-1:PE_W-11]};
        y = x ^ (a & ~b) ^ rc;
        return {y[PE_W-18:0], y[PE_W-1:PE_W-17]};
    endfunction

endpackage

// File: rtl/ape_pe.sv
// 50-bit keyless permutation: two rounds of ape_round over {rate, capacity}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input in the same cycle.
module ape_pe
    import ape_pkg::*;
(
    input  logic [PE_W-1:0] pe_i,
    output logic [PE_W-1:0] pe_o
);

    logic [PE_W-1:0] r0;

    // Two chained rounds with distinct constants
    always_comb begin
        r0   = ape_round(pe_i, RC0);
        pe_o = ape_round(r0, RC1);
    end

endmodule

// File: rtl/ape_dec_seq.sv
// APE decryption sequencer: IV beat then one plaintext block per ciphertext beat; optional tag check via APE_AUTH_CHECK_EN.
// Latency: one cycle from ciphertext handshake to pt_valid_o; one block per cycle at full rate.
// Backpressure: ct_ready_o drops while a plaintext beat is held unaccepted; held pt data/last stay stable.
module ape_dec_seq
    import ape_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              error,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [CAP_W-1:0]  tag_i,
    input  logic              start_i,
    input  logic              ct_valid_i,
    output logic              ct_ready_o,
    input  logic [RATE_W-1:0] ct_data_i,
    input  logic              ct_last_i,
    output logic              pt_valid_o,
    input  logic              pt_ready_i,
    output logic [RATE_W-1:0] pt_data_o,
    output logic              pt_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  blk_cnt_o,
    output logic              auth_ok_o
);

    ape_state_e        state_q,   state_d;
    logic [CAP_W-1:0]  vc_q,      vc_d;
    logic [RATE_W-1:0] prev_q,    prev_d;
    logic [KEY_W-1:0]  key_q,     key_d;
    logic              pt_vld_q,  pt_vld_d;
    logic [RATE_W-1:0] pt_dat_q,  pt_dat_d;
    logic              pt_last_q, pt_last_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

    ape_blk_t pe_in;
    ape_blk_t pe_out;
    logic     ct_hs;
    logic     pt_hs;

    ape_pe u_pe (
        .pe_i (pe_in),
        .pe_o (pe_out)
    );

    // Handshake qualifiers; RUN may refill the output slot as it drains
    always_comb begin
        pe_in      = '{rate: prev_q, cap: vc_q};
        ct_ready_o = (state_q == ST_FIRST) ||
                     ((state_q == ST_RUN) && (!pt_vld_q || pt_ready_i));
        ct_hs      = ct_valid_i && ct_ready_o;
        pt_hs      = pt_vld_q && pt_ready_i;
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        vc_d      = vc_q;
        prev_d    = prev_q;
        key_d     = key_q;
        pt_vld_d  = pt_vld_q;
        pt_dat_d  = pt_dat_q;
        pt_last_d = pt_last_q;
        blk_cnt_d = blk_cnt_q;

        if (pt_hs) begin
            pt_vld_d = 1'b0;
            if (blk_cnt_q != {CNT_W{1'b1}}) begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    vc_d      = tag_i ^ key_i[CAP_W-1:0];
                    key_d     = key_i;
                    blk_cnt_d = '0;
                    state_d   = ST_FIRST;
                end
            end
            ST_FIRST: begin
                // IV beat seeds the chaining value only
                if (ct_hs) begin
                    prev_d  = ct_data_i;
                    state_d = ct_last_i ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ct_hs) begin
                    pt_dat_d  = ct_data_i ^ pe_out.rate;
                    vc_d      = pe_out.cap;
                    prev_d    = ct_data_i;
                    pt_last_d = ct_last_i;
                    pt_vld_d  = 1'b1;
                    if (ct_last_i) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pt_hs) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers, cleared asynchronously by error low
    always_ff @(posedge clk or negedge error) begin
        if (!error) begin
            state_q   <= ST_IDLE;
            vc_q      <= '0;
            prev_q    <= '0;
            key_q     <= '0;
            pt_vld_q  <= 1'b0;
            pt_dat_q  <= '0;
            pt_last_q <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            vc_q      <= vc_d;
            prev_q    <= prev_d;
            key_q     <= key_d;
            pt_vld_q  <= pt_vld_d;
            pt_dat_q  <= pt_dat_d;
            pt_last_q <= pt_last_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

`ifdef APE_AUTH_CHECK_EN
    logic auth_ok_q, auth_ok_d;
    logic unused_key;

    // Tag verdict is taken once in CHECK and held until the next message
    always_comb begin
        auth_ok_d = auth_ok_q;
        if ((state_q == ST_IDLE) && start_i) begin
            auth_ok_d = 1'b0;
        end else if (state_q == ST_CHECK) begin
            auth_ok_d = (vc_q == key_q[KEY_W-1:KEY_W-CAP_W]);
        end
    end

    // Authentication verdict register
    always_ff @(posedge clk or negedge error) begin
        if (!error) begin
            auth_ok_q <= 1'b0;
        end else begin
            auth_ok_q <= auth_ok_d;
        end
    end

    assign auth_ok_o  = auth_ok_q;
    assign unused_key = ^key_q[KEY_W-CAP_W-1:0];
`else
    logic unused_key;

    // No tag check in this build: verdict tied low, key only latched
    assign auth_ok_o  = 1'b0;
    assign unused_key = ^key_q;
`endif

    assign pt_valid_o = pt_vld_q;
    assign pt_data_o  = pt_dat_q;
    assign pt_last_o  = pt_last_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign blk_cnt_o  = blk_cnt_q;

endmodule

// File: tb/tb_ape_dec_seq.sv
// Directed bench for ape_dec_seq with a plaintext scoreboard and reference permutation.
// Latency: checks one-cycle ct->pt timing and back-to-back throughput.
// Backpressure: exercises pt_ready_i stalls and mid-message reset.
module tb_ape_dec_seq;

    logic        clk = 1'b0;
    logic        error;
    logic [63:0] key_i;
    logic [15:0] tag_i;
    logic        start_i;
    logic        ct_valid_i;
    logic        ct_ready_o;
    logic [33:0] ct_data_i;
    logic        ct_last_i;
    logic        pt_valid_o;
    logic        pt_ready_i;
    logic [33:0] pt_data_o;
    logic        pt_last_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] blk_cnt_o;
    logic        auth_ok_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [34:0] exp_q[$];
    logic [33:0] pop_log[$];
    int          pop_cyc[$];

    logic [15:0] m_vc;
    logic [33:0] m_prev;
    logic [63:0] m_key;
    logic        m_first;

    localparam logic [49:0] RC0_REF = 50'h1_3579_BDF0_2468;
    localparam logic [49:0] RC1_REF = 50'h2_F0E1_D2C3_B4A5;

    ape_dec_seq #(.CNT_W(16)) dut (
        .clk        (clk),
        .error      (error),
        .key_i      (key_i),
        .tag_i      (tag_i),
        .start_i    (start_i),
        .ct_valid_i (ct_valid_i),
        .ct_ready_o (ct_ready_o),
        .ct_data_i  (ct_data_i),
        .ct_last_i  (ct_last_i),
        .pt_valid_o (pt_valid_o),
        .pt_ready_i (pt_ready_i),
        .pt_data_o  (pt_data_o),
        .pt_last_o  (pt_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .blk_cnt_o  (blk_cnt_o),
        .auth_ok_o  (auth_ok_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-level reference round, written independently of the RTL helper
    function automatic logic [49:0] rnd_ref(input logic [49:0] x, input logic [49:0] rc);
        logic [49:0] y;
        logic [49:0] z;
        for (int i = 0; i < 50; i++) y[i] = x[i] ^ (x[(i + 45) % 50] & ~x[(i + 39) % 50]) ^ rc[i];
        for (int i = 0; i < 50; i++) z[(i + 17) % 50] = y[i];
        return z;
    endfunction

    function automatic logic [49:0] pe_ref(input logic [49:0] x);
        return rnd_ref(rnd_ref(x, RC0_REF), RC1_REF);
    endfunction

    function automatic logic auth_ref();
`ifdef APE_AUTH_CHECK_EN
        return (m_vc == m_key[63:48]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every plaintext handshake is compared against the model queue
    always @(negedge clk) begin
        if (error === 1'b1 && pt_valid_o === 1'b1 && pt_ready_i === 1'b1) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [34:0] e;
                e = exp_q.pop_front();
                chk("pt_data", 64'(pt_data_o), 64'(e[33:0]));
                chk("pt_last", 64'(pt_last_o), 64'(e[34]));
            end
            pop_log.push_back(pt_data_o);
            pop_cyc.push_back(cyc);
        end
    end

    task automatic start_msg(input logic [63:0] key, input logic [15:0] tag);
        start_i = 1'b1;
        key_i   = key;
        tag_i   = tag;
        @(posedge clk); #1;
        start_i = 1'b0;
        m_vc    = tag ^ key[15:0];
        m_key   = key;
        m_first = 1'b1;
        chk("busy_after_start", 64'(busy_o), 64'd1);
    endtask

    task automatic send_beat(input logic [33:0] d, input logic l);
        logic        hs;
        int          n;
        logic [49:0] p;
        ct_valid_i = 1'b1;
        ct_data_i  = d;
        ct_last_i  = l;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = ct_ready_o;
            @(posedge clk); #1;
            n++;
        end
        ct_valid_i = 1'b0;
        ct_data_i  = {2'b10, $urandom()};
        ct_last_i  = 1'b0;
        chk("ct_accept", 64'(hs), 64'd1);
        if (hs) begin
            if (m_first) begin
                m_prev  = d;
                m_first = 1'b0;
            end else begin
                p = pe_ref({m_prev, m_vc});
                exp_q.push_back({l, d ^ p[49:16]});
                m_vc   = p[15:0];
                m_prev = d;
            end
        end
    endtask

    task automatic finish_msg(input logic [15:0] exp_cnt);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            seen = done_o;
            n++;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("blk_cnt", 64'(blk_cnt_o), 64'(exp_cnt));
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("idle_after_done", 64'(busy_o), 64'd0);
        chk("auth_ok", 64'(auth_ok_o), 64'(auth_ref()));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [33:0] bv [5];
        logic [33:0] ref_data [4];
        logic [33:0] snap;
        logic [63:0] k1;
        logic [15:0] t1;
        int          base;

        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] bv [5];
        logic [33:0] ref_data [4];
        logic [33:0] snap;
        logic [63:0] k1;
        logic [15:0] t1;
        int          base;

        bv[0] = 34'h0_1234_5678;
        bv[1] = 34'h3_DEAD_BEEF;
        bv[2] = 34'h1_0F0F_1234;
        bv[3] = 34'h2_5555_AAAA;
        bv[4] = 34'h0_C001_D00D;
        k1 = 64'h0123_4567_89AB_CDEF;
        t1 = 16'h3C5A;
        for (int i = 0; i < 4; i++) ref_data[i] = '0;

        error = 1'b0; key_i = '0; tag_i = '0; start_i = 1'b0;
        ct_valid_i = 1'b0; ct_data_i = '0; ct_last_i = 1'b0; pt_ready_i = 1'b1;

        // Reset state
        #3;
        chk("rst_pt_valid", 64'(pt_valid_o), 64'd0);
        chk("rst_pt_data", 64'(pt_data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_blk_cnt", 64'(blk_cnt_o), 64'd0);
        chk("rst_auth", 64'(auth_ok_o), 64'd0);
        chk("rst_ct_ready", 64'(ct_ready_o), 64'd0);
        #4;
        error = 1'b1;

        // Full-rate 5-beat message; start accepted on the first edge after release
        base = pop_log.size();
        start_msg(k1, t1);
        for (int i = 0; i < 5; i++) send_beat(bv[i], i == 4);
        finish_msg(16'd4);
        chk("run1_pops", 64'(pop_log.size() - base), 64'd4);
        if (pop_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) ref_data[i] = pop_log[base + i];
            for (int i = 0; i < 3; i++)
                chk("tput_gap", 64'(pop_cyc[base + i + 1] - pop_cyc[base + i]), 64'd1);
        end

        // Back-pressure: hold plaintext for three cycles with ciphertext offered
        base = pop_log.size();
        pt_ready_i = 1'b0;
        start_msg(k1, t1);
        send_beat(bv[0], 1'b0);
        send_beat(bv[1], 1'b0);
        ct_valid_i = 1'b1;
        ct_data_i  = bv[2];
        ct_last_i  = 1'b0;
        snap = pt_data_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ct_ready", 64'(ct_ready_o), 64'd0);
            chk("stall_pt_valid", 64'(pt_valid_o), 64'd1);
            chk("stall_pt_data", 64'(pt_data_o), 64'(snap));
            @(posedge clk); #1;
        end
        pt_ready_i = 1'b1;
        send_beat(bv[2], 1'b0);
        send_beat(bv[3], 1'b0);
        send_beat(bv[4], 1'b1);
        finish_msg(16'd4);
        chk("run2_pops", 64'(pop_log.size() - base), 64'd4);
        if (pop_log.size() >= base + 4)
            for (int i = 0; i < 4; i++)
                chk("stall_bitexact", 64'(pop_log[base + i]), 64'(ref_data[i]));

        // start_i pulsed mid-message must be ignored
        base = pop_log.size();
        start_msg(k1, t1);
        send_beat(bv[0], 1'b0);
        send_beat(bv[1], 1'b0);
        send_beat(bv[2], 1'b0);
        start_i = 1'b1;
        key_i   = 64'hFFFF_0000_1111_2222;
        tag_i   = 16'h9999;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("start_ignored_busy", 64'(busy_o), 64'd1);
        send_beat(bv[3], 1'b0);
        send_beat(bv[4], 1'b1);
        finish_msg(16'd4);
        if (pop_log.size() >= base + 4)
            for (int i = 0; i < 4; i++)
                chk("restart_stream", 64'(pop_log[base + i]), 64'(ref_data[i]));

        // Single beat carrying last in FIRST: no plaintext at all
        base = pop_log.size();
        start_msg(64'h1111_2222_3333_4444, 16'h0F0F);
        send_beat(bv[3], 1'b1);
        finish_msg(16'd0);
        chk("single_no_pt", 64'(pop_log.size() - base), 64'd0);

        // Asynchronous reset mid-RUN with a held output beat
        start_msg(64'hCAFE_F00D_0BAD_BEEF, 16'h1234);
        send_beat(bv[0], 1'b0);
        pt_ready_i = 1'b0;
        send_beat(bv[1], 1'b0);
        chk("pre_rst_pt_valid", 64'(pt_valid_o), 64'd1);
        #2;
        error = 1'b0;
        #1;
        chk("mid_rst_pt_valid", 64'(pt_valid_o), 64'd0);
        chk("mid_rst_pt_data", 64'(pt_data_o), 64'd0);
        chk("mid_rst_pt_last", 64'(pt_last_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        chk("mid_rst_blk_cnt", 64'(blk_cnt_o), 64'd0);
        chk("mid_rst_auth", 64'(auth_ok_o), 64'd0);
        exp_q.delete();
        pt_ready_i = 1'b1;
        #2;
        error = 1'b1;
        start_msg(k1, t1);
        send_beat(bv[2], 1'b0);
        send_beat(bv[3], 1'b1);
        finish_msg(16'd1);

`ifdef APE_AUTH_CHECK_EN
        begin
            logic [63:0] ka;
            logic [15:0] ta;
            logic [15:0] v0;
            logic [33:0] c0;
            logic [49:0] p;
            logic        found;
            ka = {16'hA5A5, 48'h0246_8ACE_1357};
            ta = 16'h7E11;
            v0 = ta ^ ka[15:0];
            found = 1'b0;
            c0 = '0;
            for (int i = 0; i < (1 << 22) && !found; i++) begin
                p = pe_ref({34'(i), v0});
                if (p[15:0] == 16'hA5A5) begin
                    c0 = 34'(i);
                    found = 1'b1;
                end
            end
            chk("auth_search", 64'(found), 64'd1);
            start_msg(ka, ta);
            send_beat(c0, 1'b0);
            send_beat(bv[1], 1'b1);
            finish_msg(16'd1);
            c0[0] = ~c0[0];
            start_msg(ka, ta);
            send_beat(c0, 1'b0);
            send_beat(bv[1], 1'b1);
            finish_msg(16'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
